// File: rtl/nco_pedal_pkg.sv
// Shared types and defaults for the NCO pedal blocks (tremolo, auto-pan).
package nco_pedal_pkg;
  localparam int MPR_DEF = 26;
  localparam int ADW_DEF = 24;
  localparam int DW_DEF  = 8;
  localparam int GW      = 17;
  localparam logic [GW-1:0] GAIN_UNITY = 17'h10000;

  typedef enum logic [1:0] {
    WAIT_LFO = 2'd0,
    RUN      = 2'd1,
    PEND     = 2'd2
  } trem_state_t;
endpackage

// File: rtl/tremolo_gain_calc.sv
// Combinational LFO/depth to unipolar gain (257..65536, unity = 65536).
module tremolo_gain_calc
  import nco_pedal_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [15:0]   lfo_msb,
  input  logic [DW-1:0] depth,
  input  logic          unity,
  output logic [GW-1:0] gain
);
  logic [15:0]    u;
  logic [15:0]    span;
  logic [DW+15:0] scaled;

  always_comb begin
    u      = lfo_msb ^ 16'h8000;
    span   = 16'hFFFF - u;
    scaled = {16'b0, depth} * {{DW{1'b0}}, span};
    gain   = unity ? GAIN_UNITY : (GAIN_UNITY - {1'b0, scaled[DW+15:DW]});
  end
endmodule

// File: rtl/nco_tremolo_mod.sv
// Tremolo: NCO sine -> gain applied to a valid/ready audio stream, 2-stage pipeline.
// Define TREMOLO_ROUND_EN for round-half-up with saturation instead of floor.
module nco_tremolo_mod
  import nco_pedal_pkg::*;
#(
  parameter int MPR = MPR_DEF,
  parameter int ADW = ADW_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic signed [MPR-1:0] lfo_i,
  input  logic                  lfo_valid_i,
  input  logic [DW-1:0]         depth_i,
  input  logic signed [ADW-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic signed [ADW-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [1:0]            state_o
);
  logic signed [MPR-1:0] lfo_q;
  logic [DW-1:0]         depth_act;
  trem_state_t           state;
  logic                  adv;
  logic [GW-1:0]         g_now;
  logic signed [ADW-1:0] data_p1;
  logic [GW-1:0]         g_p1;
  logic                  vld_p1;
  logic signed [ADW+17:0] prod_p1;
  logic                  lfo_lsb_unused;

`ifdef TREMOLO_ROUND_EN
  localparam logic signed [ADW+18:0] SAT_MAX = {{20{1'b0}}, {(ADW-1){1'b1}}};
  localparam logic signed [ADW+18:0] SAT_MIN = {{20{1'b1}}, {(ADW-1){1'b0}}};

  function automatic logic signed [ADW-1:0] scale_out(input logic signed [ADW+17:0] p);
    logic signed [ADW+18:0] r;
    r = ((ADW+19)'(p) + (ADW+19)'(32768)) >>> 16;
    if (r > SAT_MAX)      return {1'b0, {(ADW-1){1'b1}}};
    else if (r < SAT_MIN) return {1'b1, {(ADW-1){1'b0}}};
    else                  return ADW'(r);
  endfunction
`else
  function automatic logic signed [ADW-1:0] scale_out(input logic signed [ADW+17:0] p);
    return ADW'(p >>> 16);
  endfunction
`endif

  assign adv            = clken && (!m_valid_o || m_ready_i);
  assign s_ready_o      = adv && reset_n;
  assign state_o        = state;
  assign lfo_lsb_unused = ^lfo_q[MPR-17:0];

  tremolo_gain_calc #(.DW(DW)) u_gain (
    .lfo_msb (lfo_q[MPR-1 -: 16]),
    .depth   (depth_act),
    .unity   (state == WAIT_LFO),
    .gain    (g_now)
  );

  // Depth changes are held back until the LFO crosses upward through zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfo_q     <= '0;
      depth_act <= '0;
      state     <= WAIT_LFO;
    end else if (clken) begin
      if (lfo_valid_i) lfo_q <= lfo_i;
      case (state)
        WAIT_LFO: if (lfo_valid_i) begin
          depth_act <= depth_i;
          state     <= RUN;
        end
        RUN: if (depth_i != depth_act) state <= PEND;
        PEND: begin
          if (lfo_valid_i && lfo_q[MPR-1] && !lfo_i[MPR-1]) begin
            depth_act <= depth_i;
            state     <= RUN;
          end else if (depth_i == depth_act) begin
            state <= RUN;
          end
        end
        default: state <= WAIT_LFO;
      endcase
    end
  end

  assign prod_p1 = (ADW+18)'(data_p1) * (ADW+18)'($signed({1'b0, g_p1}));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p1   <= '0;
      g_p1      <= GAIN_UNITY;
      vld_p1    <= 1'b0;
      m_data_o  <= '0;
      m_valid_o <= 1'b0;
    end else if (adv) begin
      // stage 1: capture sample with the gain of the current LFO value
      data_p1   <= s_data_i;
      g_p1      <= g_now;
      vld_p1    <= s_valid_i;
      // stage 2: scale and present downstream
      m_data_o  <= scale_out(prod_p1);
      m_valid_o <= vld_p1;
    end
  end
endmodule

// File: tb/tb_nco_tremolo_mod.sv
// Scoreboard bench for nco_tremolo_mod: reference gain model, stall and reset scenarios.
module tb_nco_tremolo_mod;
  localparam int MPR = 26;
  localparam int ADW = 24;
  localparam int DW  = 8;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  clken = 1'b1;
  logic [MPR-1:0]        lfo_i = '0;
  logic                  lfo_valid_i = 1'b0;
  logic [DW-1:0]         depth_i = '0;
  logic [ADW-1:0]        s_data_i = '0;
  logic                  s_valid_i = 1'b0;
  logic                  s_ready_o;
  logic signed [ADW-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_ready_i = 1'b1;
  logic [1:0]            state_o;

  nco_tremolo_mod #(.MPR(MPR), .ADW(ADW), .DW(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clken       (clken),
    .lfo_i       (lfo_i),
    .lfo_valid_i (lfo_valid_i),
    .depth_i     (depth_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  longint exp_q[$];
  int md_state = 0;
  int md_depth = 0;
  logic [MPR-1:0] md_lfo = '0;
  bit held_vld = 1'b0;
  logic signed [ADW-1:0] held_data = '0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint model_out(input logic [ADW-1:0] s, input logic [MPR-1:0] lfo,
                                       input int depth, input bit unity);
    longint g, u, p, r;
    if (unity) g = 65536;
    else begin
      u = longint'(lfo[MPR-1:MPR-16]) ^ 32768;
      g = 65536 - ((longint'(depth) * (65535 - u)) >>> DW);
    end
    p = longint'($signed(s)) * g;
`ifdef TREMOLO_ROUND_EN
    r = (p + 32768) >>> 16;
    if (r > 8388607) r = 8388607;
    if (r < -8388608) r = -8388608;
`else
    r = p >>> 16;
`endif
    return r;
  endfunction

  // Monitor + reference model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      md_state = 0;
      md_depth = 0;
      md_lfo   = '0;
      held_vld = 1'b0;
    end else if (clken) begin
      check_eq("state", state_o, md_state);
      if (m_valid_o) begin
        if (held_vld) check_eq("stall_hold", m_data_o, held_data);
        if (m_ready_i) begin
          if (exp_q.size() == 0) check_eq("spurious_out", exp_q.size(), 1);
          else check_eq("data", m_data_o, exp_q.pop_front());
          held_vld = 1'b0;
        end else begin
          held_vld  = 1'b1;
          held_data = m_data_o;
        end
      end
      if (s_valid_i && s_ready_o)
        exp_q.push_back(model_out(s_data_i, md_lfo, md_depth, md_state == 0));
      case (md_state)
        0: if (lfo_valid_i) begin md_state = 1; md_depth = int'(depth_i); end
        1: if (int'(depth_i) != md_depth) md_state = 2;
        2: begin
          if (lfo_valid_i && md_lfo[MPR-1] && !lfo_i[MPR-1]) begin
            md_depth = int'(depth_i);
            md_state = 1;
          end else if (int'(depth_i) == md_depth) md_state = 1;
        end
        default: ;
      endcase
      if (lfo_valid_i) md_lfo = lfo_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ADW-1:0] d);
    bit done;
    done = 1'b0;
    s_data_i  = d;
    s_valid_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (s_ready_o) done = 1'b1;
      step();
    end
    s_valid_i = 1'b0;
    check_eq("accept", done, 1);
  endtask

  task automatic strobe(input logic [MPR-1:0] v);
    lfo_i       = v;
    lfo_valid_i = 1'b1;
    step();
    lfo_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    logic [ADW-1:0] cur;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_valid", m_valid_o, 0);
    check_eq("rst_m_data", m_data_o, 0);
    check_eq("rst_s_ready", s_ready_o, 0);
    check_eq("rst_state", state_o, 0);
    reset_n = 1'b1;
    depth_i = 8'd255;
    step();

    // Unity gain before any LFO sample; 2-cycle latency
    send(24'h100000);
    step();
    check_eq("t1_valid", m_valid_o, 1);
    check_eq("t1_data", m_data_o, 'h100000);
    check_eq("t1_state", state_o, 0);
    drain();

    // Most negative LFO at full depth -> g=257
    strobe(26'h2000001);
    check_eq("t2_state", state_o, 1);
    send(24'd1048576);
    step();
    check_eq("t2_data", m_data_o, 4112);
    drain();

    // Depth change deferred to upward crossing, then lfo=0 at depth 128
    depth_i = 8'd128;
    step();
    check_eq("t3_pend", state_o, 2);
    strobe(26'h0000000);
    check_eq("t3_run", state_o, 1);
    send(24'd65536);
    step();
    check_eq("t3_data", m_data_o, 49153);
    drain();

    // Streaming with downstream stall on cycles 3-5 and an LFO update mid-stream
    sent = 0;
    cur = 24'($urandom);
    for (int cyc = 0; cyc < 40; cyc++) begin
      m_ready_i   = !(cyc >= 3 && cyc <= 5);
      lfo_valid_i = (cyc == 4);
      lfo_i       = 26'h0400000;
      s_valid_i   = (sent < 8);
      s_data_i    = cur;
      #1;
      if (s_valid_i && s_ready_o) begin
        sent++;
        cur = 24'($urandom);
      end
      step();
    end
    lfo_valid_i = 1'b0;
    s_valid_i   = 1'b0;
    m_ready_i   = 1'b1;
    check_eq("t4_sent", sent, 8);
    drain();

    // Reach depth 0, then request 200 while LFO positive
    depth_i = 8'd0;
    step();
    strobe(26'h3000000);
    strobe(26'h0800000);
    check_eq("t5_run0", state_o, 1);
    depth_i = 8'd200;
    step();
    check_eq("t5_pend", state_o, 2);
    send(24'h012345);
    step();
    check_eq("t5_unity", m_data_o, 'h012345);
    drain();
    strobe(26'h3000000);
    check_eq("t5_still_pend", state_o, 2);
    strobe(26'h0800000);
    check_eq("t5_run200", state_o, 1);
    send(24'd65536);
    step();
    check_eq("t5_data", m_data_o, 46337);
    drain();

    // clken low freezes everything
    m_ready_i = 1'b0;
    send(24'h000400);
    step();
    clken = 1'b0;
    step();
    check_eq("ce_s_ready", s_ready_o, 0);
    check_eq("ce_m_valid", m_valid_o, 1);
    clken = 1'b1;
    m_ready_i = 1'b1;
    drain();

    // Reset mid-stream discards in-flight samples
    m_ready_i = 1'b0;
    send(24'h7FFFFF);
    send(24'h800000);
    step();
    check_eq("t6_pre_valid", m_valid_o, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t6_m_valid", m_valid_o, 0);
    check_eq("t6_m_data", m_data_o, 0);
    check_eq("t6_s_ready", s_ready_o, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check_eq("t6_state", state_o, 0);
    check_eq("t6_valid_after", m_valid_o, 0);
    m_ready_i = 1'b1;
    send(24'h020000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
